// File: rtl/servo_cmd_pkg.sv
// Shared constants and state encodings for the servo UART command controller.
package servo_cmd_pkg;

  localparam logic [7:0] ST_ACK    = 8'h06;
  localparam logic [7:0] ST_CLAMP  = 8'h07;
  localparam logic [7:0] ST_NAK    = 8'h15;
  localparam logic [7:0] TERM_BYTE = 8'h0A;
  localparam int         REPLY_LEN = 4;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_B1    = 3'd1,
    P_B2    = 3'd2,
    P_CK    = 3'd3,
    P_TERM  = 3'd4,
    P_APPLY = 3'd5
  } parse_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_WAIT = 2'd2
  } resp_t;

endpackage

// File: rtl/servo_cmd_tx_seq.sv
// Four-byte status responder: the code byte, then the width MSB first, paced by tx_busy.
module servo_cmd_tx_seq
  import servo_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [7:0]  req_code,
  input  logic [23:0] req_width,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        active,
  output logic        drop
);

  localparam logic [1:0] LAST = 2'(REPLY_LEN - 1);

  resp_t       st, nxt;
  logic [1:0]  idx, wcnt;
  logic [23:0] wbuf;

  always_comb begin
    nxt   = st;
    tx_en = 1'b0;
    case (st)
      R_IDLE: if (req) nxt = R_LOAD;
      R_LOAD: if (!tx_busy) begin
        tx_en = 1'b1;
        nxt   = R_WAIT;
      end
      // The UART may take a couple of cycles to raise busy, so it is not trusted until then.
      R_WAIT: if (wcnt == 2'd2 && !tx_busy) nxt = (idx == LAST) ? R_IDLE : R_LOAD;
      default: nxt = R_IDLE;
    endcase
  end

  assign active = (st != R_IDLE);
  assign drop   = req && active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st      <= R_IDLE;
      idx     <= '0;
      wcnt    <= '0;
      wbuf    <= '0;
      tx_data <= '0;
    end else begin
      st <= nxt;
      case (st)
        R_IDLE: if (req) begin
          tx_data <= req_code;
          wbuf    <= req_width;
          idx     <= '0;
        end
        R_LOAD: wcnt <= '0;
        R_WAIT: begin
          if (wcnt != 2'd2) wcnt <= wcnt + 2'd1;
          else if (!tx_busy && idx != LAST) begin
            idx     <= idx + 2'd1;
            tx_data <= wbuf[23:16];
            wbuf    <= {wbuf[15:0], 8'h00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/servo_cmd_ctrl.sv
// Servo command parser: framed 24-bit width, clamp, width register and status reply.
// Optional checksum byte enabled by defining SERVO_CMD_CHECKSUM_EN.
module servo_cmd_ctrl
  import servo_cmd_pkg::*;
#(
  parameter int CLK_HZ      = 27_000_000,
  parameter int DEFAULT_PW  = 54054,
  parameter int MIN_PW      = 27000,
  parameter int MAX_PW      = 67500,
  parameter int TIMEOUT_CYC = CLK_HZ / 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [23:0] pwm_width,
  output logic        pw_update,
  output logic [3:0]  status
);

  localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [23:0] MIN_W = 24'(MIN_PW);
  localparam logic [23:0] MAX_W = 24'(MAX_PW);
  localparam logic [23:0] DEF_W = 24'(DEFAULT_PW);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  parse_t        st, nxt;
  logic [7:0]    w2, w1, w0;
  logic [23:0]   w_raw, w_clamp;
  logic [7:0]    apply_code, req_code;
  logic [TW-1:0] idle_cnt;
  logic          term_ok, timeout, rej_now;
  logic          req, drop, active, tog, rej, ovr;
`ifdef SERVO_CMD_CHECKSUM_EN
  logic [7:0]    ck;
`endif

  assign w_raw = {w2, w1, w0};

  always_comb begin
    w_clamp    = w_raw;
    apply_code = ST_ACK;
    if (w_raw < MIN_W) begin
      w_clamp    = MIN_W;
      apply_code = ST_CLAMP;
    end else if (w_raw > MAX_W) begin
      w_clamp    = MAX_W;
      apply_code = ST_CLAMP;
    end
  end

`ifdef SERVO_CMD_CHECKSUM_EN
  assign term_ok = (rx_data == TERM_BYTE) && (ck == (w2 ^ w1 ^ w0));
`else
  assign term_ok = (rx_data == TERM_BYTE);
`endif

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (idle_cnt == TO_LAST) && !rx_valid;
  assign rej_now = (st == P_TERM) && rx_valid && !term_ok;

  always_comb begin
    nxt = st;
    case (st)
      P_IDLE:  if (rx_valid) nxt = P_B1;
      P_B1:    if (rx_valid) nxt = P_B2;
`ifdef SERVO_CMD_CHECKSUM_EN
      P_B2:    if (rx_valid) nxt = P_CK;
      P_CK:    if (rx_valid) nxt = P_TERM;
`else
      P_B2:    if (rx_valid) nxt = P_TERM;
`endif
      P_TERM:  if (rx_valid) nxt = term_ok ? P_APPLY : P_IDLE;
      P_APPLY: nxt = P_IDLE;
      default: nxt = P_IDLE;
    endcase
    if (st != P_IDLE && st != P_APPLY && timeout) nxt = P_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= P_IDLE;
      idle_cnt <= '0;
      w2       <= '0;
      w1       <= '0;
      w0       <= '0;
`ifdef SERVO_CMD_CHECKSUM_EN
      ck       <= '0;
`endif
    end else begin
      st <= nxt;
      if (st == P_IDLE || st == P_APPLY || rx_valid) idle_cnt <= '0;
      else                                            idle_cnt <= idle_cnt + 1'b1;
      if (rx_valid) begin
        case (st)
          P_IDLE: w2 <= rx_data;
          P_B1:   w1 <= rx_data;
          P_B2:   w0 <= rx_data;
`ifdef SERVO_CMD_CHECKSUM_EN
          P_CK:   ck <= rx_data;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_width <= DEF_W;
      pw_update <= 1'b0;
      req       <= 1'b0;
      req_code  <= '0;
      tog       <= 1'b0;
      rej       <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      pw_update <= 1'b0;
      req       <= 1'b0;
      if (st == P_APPLY) begin
        pwm_width <= w_clamp;
        pw_update <= 1'b1;
        tog       <= ~tog;
        req       <= 1'b1;
        req_code  <= apply_code;
      end
      if (rej_now) begin
        rej      <= 1'b1;
        req      <= 1'b1;
        req_code <= ST_NAK;
      end
      if (drop) ovr <= 1'b1;
    end
  end

  // The responder samples pwm_width one cycle after APPLY, so it sees the updated value.
  servo_cmd_tx_seq u_tx (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_code  (req_code),
    .req_width (pwm_width),
    .tx_busy   (tx_busy),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .active    (active),
    .drop      (drop)
  );

  assign status = {active, ovr, rej, tog};

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// Directed bench for servo_cmd_ctrl with a short timeout and a simple UART busy model.
module tb_servo_cmd_ctrl;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [23:0] pwm_width;
  logic        pw_update;
  logic [3:0]  status;

  logic        busy_hold = 1'b0;
  int          busy_cnt = 0;
  logic        en_q = 1'b0;
  logic [7:0]  txq[$];
  int          upd_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  servo_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_busy   (tx_busy),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .pwm_width (pwm_width),
    .pw_update (pw_update),
    .status    (status)
  );

  always #5 clk = ~clk;

  assign tx_busy = busy_hold || (busy_cnt != 0);

  always @(negedge clk) begin
    en_q <= tx_en;
    if (pw_update) upd_cnt <= upd_cnt + 1;
    if (tx_en) begin
      txq.push_back(tx_data);
      n_vec <= n_vec + 1;
      assert (tx_busy === 1'b0) else begin
        n_err <= n_err + 1;
        $error("FAIL tx_en_while_busy observed busy=%b required 0", tx_busy);
      end
    end
  end

  always @(posedge clk) begin
    if (en_q)              busy_cnt <= 6;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] t);
    send_byte(a);
    send_byte(b);
    send_byte(c);
`ifdef SERVO_CMD_CHECKSUM_EN
    send_byte(a ^ b ^ c);
`endif
    send_byte(t);
  endtask

  task automatic check_reply(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    for (int i = 0; i < 800 && txq.size() < 4; i++) @(negedge clk);
    for (int i = 0; i < 100 && status[3]; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check({tag, "_len"}, txq.size(), 4);
    got = 32'hxxxxxxxx;
    if (txq.size() >= 4) got = {txq[0], txq[1], txq[2], txq[3]};
    check(tag, got, exp);
    txq.delete();
  endtask

  initial begin
    int u0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_width", pwm_width, 54054);
    check("rst_status", status, 0);
    check("rst_txdata", tx_data, 0);
    check("rst_pwupd", pw_update, 0);
    check("rst_no_tx", txq.size(), 0);

    // In-range width, with exact update timing.
    u0 = upd_cnt;
    send_frame(8'h00, 8'hD2, 8'hEF, 8'h0A);
    check("upd_not_at_E", pw_update, 0);
    @(negedge clk);
    check("upd_at_E1", pw_update, 1);
    check("width_53999", pwm_width, 53999);
    @(negedge clk);
    check("upd_one_cycle", pw_update, 0);
    check_reply("reply_53999", 32'h0600D2EF);
    check("upd_cnt_1", upd_cnt - u0, 1);
    check("status_tog1", status, 4'b0001);

    // Above MAX_PW clamps.
    send_frame(8'h02, 8'h00, 8'h00, 8'h0A);
    check_reply("reply_max", 32'h070107AC);
    check("width_max", pwm_width, 67500);
    check("status_tog0", status, 4'b0000);

    // Below MIN_PW clamps.
    send_frame(8'h00, 8'h01, 8'h00, 8'h0A);
    check_reply("reply_min", 32'h07006978);
    check("width_min", pwm_width, 27000);

    // Bad terminator rejects, width unchanged.
    u0 = upd_cnt;
    send_frame(8'h00, 8'h80, 8'h00, 8'h0B);
    check_reply("reply_rej", 32'h15006978);
    check("width_rej", pwm_width, 27000);
    check("upd_rej", upd_cnt - u0, 0);
    check("status_rej", status, 4'b0011);

    // Fragment dropped silently after timeout.
    send_byte(8'h00);
    send_byte(8'h80);
    repeat (TO + 5) @(negedge clk);
    check("frag_silent", txq.size(), 0);
    send_frame(8'h00, 8'hC3, 8'h50, 8'h0A);
    check_reply("reply_50000", 32'h0600C350);
    check("width_50000", pwm_width, 50000);

    // Gaps just short of the timeout keep the frame alive.
    send_byte(8'h00);
    repeat (TO - 5) @(negedge clk);
    send_byte(8'hB0);
    repeat (TO - 5) @(negedge clk);
    send_byte(8'h00);
`ifdef SERVO_CMD_CHECKSUM_EN
    send_byte(8'hB0);
`endif
    send_byte(8'h0A);
    check_reply("reply_slow", 32'h0600B000);
    check("width_slow", pwm_width, 45056);

    // Second frame while the first reply is stalled: overrun, one reply.
    busy_hold = 1'b1;
    send_frame(8'h00, 8'hD2, 8'hEF, 8'h0A);
    repeat (3) @(negedge clk);
    send_frame(8'h00, 8'hEA, 8'h60, 8'h0A);
    repeat (3) @(negedge clk);
    check("width_ovr", pwm_width, 60000);
    check("status_ovr", status, 4'b1111);
    check("ovr_no_tx", txq.size(), 0);
    busy_hold = 1'b0;
    check_reply("reply_ovr", 32'h0600D2EF);
    repeat (200) @(negedge clk);
    check("ovr_one_reply", txq.size(), 0);
    check("status_after_ovr", status, 4'b0111);

    // Reset in the middle of a reply.
    send_frame(8'h00, 8'hC3, 8'h50, 8'h0A);
    for (int i = 0; i < 200 && txq.size() < 1; i++) @(negedge clk);
    check("mid_reply_started", txq.size(), 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_mid_txen", tx_en, 0);
    check("rst_mid_width", pwm_width, 54054);
    check("rst_mid_status", status, 0);
    check("rst_mid_txdata", tx_data, 0);
    check("rst_mid_pwupd", pw_update, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    txq.delete();
    repeat (100) @(negedge clk);
    check("rst_no_partial", txq.size(), 0);
    check("rst_after_status", status, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
